// File: rtl/remap_ctrl.sv
// remap_ctrl: drains outstanding AR/AW transactions before swapping the address remap prefix.
// Optional drain timeout is enabled by defining REMAP_CTRL_TIMEOUT_EN.
module remap_ctrl #(
   parameter int                BASE_W     = 5,
   parameter logic [BASE_W-1:0] RESET_BASE = 5'b10000,
   parameter int                CNT_W      = 6,
   parameter int                TIMEOUT    = 1024
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cfg_valid,
   input  logic [BASE_W-1:0] cfg_base,
   output logic              cfg_ready,
   output logic              cfg_err,
   output logic [BASE_W-1:0] cur_base,
   input  logic              s_arvalid,
   output logic              s_arready,
   output logic              m_arvalid,
   input  logic              m_arready,
   input  logic              s_awvalid,
   output logic              s_awready,
   output logic              m_awvalid,
   input  logic              m_awready,
   input  logic              rvalid,
   input  logic              rready,
   input  logic              rlast,
   input  logic              bvalid,
   input  logic              bready
);
   typedef enum logic [1:0] {IDLE, DRAIN, SWAP} state_e;
   state_e            state_q, state_d;
   logic [CNT_W-1:0]  ar_cnt_q, ar_cnt_d, aw_cnt_q, aw_cnt_d;
   logic [BASE_W-1:0] base_lat_q, base_lat_d, cur_base_q, cur_base_d;
   logic              cfg_ready_q, cfg_ready_d;
   logic              idle, ar_open, aw_open, ar_inc, ar_dec, aw_inc, aw_dec;
`ifdef REMAP_CTRL_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             err_q, err_d;
`endif
   always_comb begin
      idle      = state_q == IDLE;
      ar_open   = idle && ar_cnt_q != '1;
      aw_open   = idle && aw_cnt_q != '1;
      m_arvalid = ar_open && s_arvalid;
      s_arready = ar_open && m_arready;
      m_awvalid = aw_open && s_awvalid;
      s_awready = aw_open && m_awready;
      ar_inc    = m_arvalid && m_arready;
      ar_dec    = rvalid && rready && rlast;
      aw_inc    = m_awvalid && m_awready;
      aw_dec    = bvalid && bready;
      ar_cnt_d  = (ar_inc && !ar_dec) ? ar_cnt_q + 1'b1 :
                  (ar_dec && !ar_inc && ar_cnt_q != '0) ? ar_cnt_q - 1'b1 : ar_cnt_q;
      aw_cnt_d  = (aw_inc && !aw_dec) ? aw_cnt_q + 1'b1 :
                  (aw_dec && !aw_inc && aw_cnt_q != '0) ? aw_cnt_q - 1'b1 : aw_cnt_q;
      state_d     = state_q;
      base_lat_d  = base_lat_q;
      cur_base_d  = cur_base_q;
      cfg_ready_d = 1'b0;
`ifdef REMAP_CTRL_TIMEOUT_EN
      err_d = 1'b0;
      tmo_d = (state_q == DRAIN) ? tmo_q + 1'b1 : '0;
`endif
      unique case (state_q)
         // a timeout completes in IDLE, so the still-held cfg_valid of that cycle is not a new request
         IDLE: if (cfg_valid && !cfg_ready_q) begin
            base_lat_d = cfg_base;
            state_d    = DRAIN;
         end
         DRAIN: begin
            if (ar_cnt_q == '0 && aw_cnt_q == '0) begin
               state_d     = SWAP;
               cur_base_d  = base_lat_q;
               cfg_ready_d = 1'b1;
            end
`ifdef REMAP_CTRL_TIMEOUT_EN
            else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
               state_d     = IDLE;
               cfg_ready_d = 1'b1;
               err_d       = 1'b1;
            end
`endif
         end
         SWAP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         ar_cnt_q    <= '0;
         aw_cnt_q    <= '0;
         base_lat_q  <= RESET_BASE;
         cur_base_q  <= RESET_BASE;
         cfg_ready_q <= 1'b0;
`ifdef REMAP_CTRL_TIMEOUT_EN
         tmo_q <= '0;
         err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ar_cnt_q    <= ar_cnt_d;
         aw_cnt_q    <= aw_cnt_d;
         base_lat_q  <= base_lat_d;
         cur_base_q  <= cur_base_d;
         cfg_ready_q <= cfg_ready_d;
`ifdef REMAP_CTRL_TIMEOUT_EN
         tmo_q <= tmo_d;
         err_q <= err_d;
`endif
      end
   end
   assign cfg_ready = cfg_ready_q;
   assign cur_base  = cur_base_q;
`ifdef REMAP_CTRL_TIMEOUT_EN
   assign cfg_err = err_q;
`else
   assign cfg_err = 1'b0;
`endif
endmodule

// File: tb/tb_remap_ctrl.sv
// tb_remap_ctrl: vector table for IDLE gating plus drain/swap sequences with a cfg scoreboard.
module tb_remap_ctrl;
   logic       clock = 1'b0, reset = 1'b1, cfg_valid = 1'b0;
   logic [4:0] cfg_base = '0;
   logic       s_arvalid = 1'b0, m_arready = 1'b0, s_awvalid = 1'b0, m_awready = 1'b0;
   logic       rvalid = 1'b0, rready = 1'b0, rlast = 1'b0, bvalid = 1'b0, bready = 1'b0;
   logic       cfg_ready, cfg_err, s_arready, m_arvalid, s_awready, m_awvalid;
   logic [4:0] cur_base;
   logic       cfg_ready2, cfg_err2, s_arready2, m_arvalid2, s_awready2, m_awvalid2;
   logic [4:0] cur_base2;
   int         checks = 0, failures = 0;
   logic [4:0] sb[$];

   remap_ctrl dut (
      .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_base(cfg_base),
      .cfg_ready(cfg_ready), .cfg_err(cfg_err), .cur_base(cur_base),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .rvalid(rvalid), .rready(rready), .rlast(rlast), .bvalid(bvalid), .bready(bready)
   );

   remap_ctrl #(.CNT_W(2)) dut_sat (
      .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_base(cfg_base),
      .cfg_ready(cfg_ready2), .cfg_err(cfg_err2), .cur_base(cur_base2),
      .s_arvalid(s_arvalid), .s_arready(s_arready2), .m_arvalid(m_arvalid2), .m_arready(m_arready),
      .s_awvalid(s_awvalid), .s_awready(s_awready2), .m_awvalid(m_awvalid2), .m_awready(m_awready),
      .rvalid(rvalid), .rready(rready), .rlast(rlast), .bvalid(bvalid), .bready(bready)
   );

   always #5 clock = ~clock;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (cfg_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_cfg_ready: got 1 expected 0 at %0t", $time);
         end else begin
            logic [4:0] e;
            e = sb.pop_front();
            chk("swap_base", cur_base, e);
            chk("swap_err", cfg_err, 0);
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      {cfg_valid, s_arvalid, m_arready, s_awvalid, m_awready} = '0;
      {rvalid, rready, rlast, bvalid, bready} = '0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic drain(input logic [4:0] b, input logic [15:0] rm, input logic [15:0] lm,
                        input logic [15:0] bm, input int exp_k, input string nm);
      int seen = -1;
      cfg_valid = 1'b1;
      cfg_base  = b;
      sb.push_back(b);
      for (int k = 1; k <= exp_k + 1; k++) begin
         step();
         cfg_base = ~b;
         if (seen > 0) cfg_valid = 1'b0;
         {rvalid, rready} = {2{rm[k]}};
         rlast = lm[k];
         {bvalid, bready} = {2{bm[k]}};
         @(negedge clock);
         if (cfg_ready && seen < 0) seen = k;
         if (k <= exp_k) chk({nm, "_gate"}, {m_arvalid, s_arready, m_awvalid, s_awready}, 0);
      end
      chk({nm, "_latency"}, seen, exp_k);
      if (seen < 0) sb.delete();
      step();
      cfg_valid = 1'b0;
      {rvalid, rready, rlast, bvalid, bready} = '0;
   endtask

   typedef struct {
      logic       arv, ard, awv, awd;
      logic [3:0] exp;
   } vec_t;

   initial begin
      vec_t vt[7];
      vt[0] = '{0, 0, 0, 0, 4'b0000};
      vt[1] = '{1, 0, 0, 0, 4'b1000};
      vt[2] = '{0, 1, 0, 0, 4'b0100};
      vt[3] = '{1, 1, 0, 0, 4'b1100};
      vt[4] = '{0, 0, 1, 1, 4'b0011};
      vt[5] = '{1, 0, 0, 1, 4'b1001};
      vt[6] = '{0, 1, 1, 0, 4'b0110};

      do_reset();
      @(negedge clock);
      chk("reset_cur_base", cur_base, 5'b10000);
      chk("reset_cfg_ready", cfg_ready, 0);
      chk("reset_cfg_err", cfg_err, 0);
      step();

      foreach (vt[i]) begin
         {s_arvalid, m_arready, s_awvalid, m_awready} = {vt[i].arv, vt[i].ard, vt[i].awv, vt[i].awd};
         @(negedge clock);
         chk($sformatf("idle_pass_%0d", i), {m_arvalid, s_arready, m_awvalid, s_awready}, vt[i].exp);
         step();
      end

      do_reset();
      drain(5'b10001, 16'h0, 16'h0, 16'h0, 2, "idle_req");
      @(negedge clock);
      chk("idle_req_cur_base", cur_base, 5'b10001);
      step();

      do_reset();
      s_arvalid = 1'b1;
      m_arready = 1'b1;
      step();
      step();
      drain(5'b00101, 16'h0478, 16'h0448, 16'h0, 12, "drain_read");
      @(negedge clock);
      chk("drain_read_reopen", m_arvalid, 1);
      step();

      do_reset();
      {s_arvalid, m_arready, s_awvalid, m_awready} = 4'b1111;
      step();
      step();
      {rvalid, rready, rlast, bvalid, bready} = 5'b11111;
      step();
      {s_arvalid, m_arready, s_awvalid, m_awready} = '0;
      {rvalid, rready, rlast, bvalid, bready} = '0;
      drain(5'b01010, 16'h0006, 16'h0006, 16'h0006, 4, "simul");

      do_reset();
      s_awvalid = 1'b1;
      m_awready = 1'b1;
      step();
      step();
      step();
      @(negedge clock);
      chk("sat_gate", {m_awvalid2, s_awready2}, 0);
      chk("nonsat_pass", {m_awvalid, s_awready}, 2'b11);
      step();
      {bvalid, bready} = 2'b11;
      @(negedge clock);
      chk("sat_gate_bresp", {m_awvalid2, s_awready2}, 0);
      step();
      {bvalid, bready} = 2'b00;
      @(negedge clock);
      chk("sat_release", {m_awvalid2, s_awready2}, 2'b11);
      step();
      @(negedge clock);
      chk("sat_regate", {m_awvalid2, s_awready2}, 0);
      step();

      do_reset();
      {rvalid, rready, rlast, bvalid, bready} = 5'b11111;
      step();
      step();
      step();
      {rvalid, rready, rlast, bvalid, bready} = '0;
      {s_arvalid, s_awvalid} = 2'b11;
      @(negedge clock);
      chk("no_wrap_pass", {m_arvalid, m_awvalid}, 2'b11);
      step();
      {s_arvalid, s_awvalid} = 2'b00;
      drain(5'b11100, 16'h0, 16'h0, 16'h0, 2, "no_wrap");

      do_reset();
      s_arvalid = 1'b1;
      m_arready = 1'b1;
      step();
      {s_arvalid, m_arready} = 2'b00;
      cfg_valid = 1'b1;
      cfg_base  = 5'b00111;
      step();
      step();
      step();
      reset     = 1'b1;
      cfg_valid = 1'b0;
      step();
      reset = 1'b0;
      {rvalid, rready, rlast} = 3'b111;
      s_arvalid = 1'b1;
      @(negedge clock);
      chk("rst_drain_base", cur_base, 5'b10000);
      chk("rst_drain_ready", cfg_ready, 0);
      chk("rst_drain_idle", m_arvalid, 1);
      step();
      {rvalid, rready, rlast, s_arvalid} = '0;
      drain(5'b00011, 16'h0, 16'h0, 16'h0, 2, "rst_drain_after");

      do_reset();
      sb.push_back(5'b01100);
      sb.push_back(5'b10011);
      cfg_valid = 1'b1;
      cfg_base  = 5'b01100;
      for (int k = 1; k <= 6; k++) begin
         step();
         cfg_base  = (k >= 3) ? 5'b10011 : 5'b01100;
         cfg_valid = k < 6;
         @(negedge clock);
         chk($sformatf("b2b_ready_%0d", k), cfg_ready, (k == 2 || k == 5));
      end
      step();
      chk("b2b_scoreboard_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
